tcb_phy_converter: RTL and testbench

Data-packing converter for the TCB (Tightly Coupled Bus), inserted between a manager issuing size-encoded, LSB-aligned transfers and a memory-style subordinate addressed by byte lanes and byte enables. Requests are translated combinationally. Read data and status are realigned after the fixed response delay using request information held in a DLY-deep pipeline. Misaligned transfers are flagged and reported back as errors.

---
 rtl/tcb_phy_converter.sv | 122 ++++++++++++
 tb/tb_tcb_phy_converter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/tcb_phy_converter.sv
// TCB size/offset to byte-lane converter: requests are lane-placed combinationally,
// responses are realigned with request metadata held for the fixed response delay.
module tcb_phy_converter #(
  parameter int unsigned DLY = 1,
  parameter int unsigned ADR = 32,
  parameter int unsigned DAT = 32,
  parameter int unsigned ORD = 0
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             sub_vld,
  output logic             sub_rdy,
  input  logic             sub_wen,
  input  logic [ADR-1:0]   sub_adr,
  input  logic [1:0]       sub_siz,
  input  logic [DAT-1:0]   sub_wdt,
  output logic [DAT-1:0]   sub_rdt,
  output logic             sub_err,
  output logic             man_vld,
  input  logic             man_rdy,
  output logic             man_wen,
  output logic [ADR-1:0]   man_adr,
  output logic [DAT/8-1:0] man_ben,
  output logic [DAT-1:0]   man_wdt,
  input  logic [DAT-1:0]   man_rdt,
  input  logic             man_err,
  output logic             mal
);

  localparam int unsigned BEN = DAT / 8;
  localparam int unsigned MAX = $clog2(BEN);
  localparam int unsigned OFW = (MAX > 0) ? MAX : 1;
  localparam logic [OFW-1:0] OFM = OFW'(BEN - 1);

  typedef struct packed {
    logic [OFW-1:0] off;
    logic [1:0]     siz;
    logic           mal;
  } meta_t;

  meta_t                req;
  meta_t                rsp;
  logic [BEN-1:0][7:0]  wdt_b;
  logic [BEN-1:0][7:0]  wdt_lane;
  logic [BEN-1:0][7:0]  rdt_lane;
  logic [BEN-1:0][7:0]  rdt_b;
  logic [OFW-1:0]       w_idx;
  logic [OFW-1:0]       w_src;
  logic [OFW-1:0]       r_idx;
  logic [OFW-1:0]       r_lane;

  // Handshake: a transfer happens on a rising clk edge where sub_vld and sub_rdy are
  // both high; valid/ready pass straight through, so downstream sees the same edge.
  assign man_vld = sub_vld;
  assign sub_rdy = man_rdy;
  assign man_wen = sub_wen;
  assign man_adr = sub_adr;

  always_comb begin
    req.siz = (sub_siz > 2'(MAX)) ? 2'(MAX) : sub_siz;
    req.off = sub_adr[OFW-1:0] & OFM;
    req.mal = sub_vld & ((req.off & OFW'((1 << req.siz) - 1)) != '0);
  end

  assign mal   = req.mal;
  assign wdt_b = sub_wdt;

  // Walk the lanes: each lane finds its relative byte index from the offset.
  always_comb begin
    man_ben  = '0;
    wdt_lane = '0;
    w_idx    = '0;
    w_src    = '0;
    for (int j = 0; j < BEN; j++) begin
      w_idx = (OFW'(j) - req.off) & OFM;
      if (int'(w_idx) < (1 << req.siz)) begin
        w_src       = (ORD != 0) ? (OFW'((1 << req.siz) - 1) - w_idx) : w_idx;
        man_ben[j]  = 1'b1;
        wdt_lane[j] = wdt_b[w_src];
      end
    end
  end

  assign man_wdt = wdt_lane;

  generate
    if (DLY == 0) begin : g_nodly
      assign rsp = rst ? req : '0;
    end else begin : g_dly
      meta_t pipe [DLY];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < DLY; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= req;
          for (int i = 1; i < DLY; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign rsp = pipe[DLY-1];
    end
  endgenerate

  assign rdt_lane = man_rdt;

  // Inverse of the write mapping, using the metadata of the responding request.
  always_comb begin
    rdt_b  = '0;
    r_idx  = '0;
    r_lane = '0;
    for (int i = 0; i < BEN; i++) begin
      if (i < (1 << rsp.siz)) begin
        r_idx    = (ORD != 0) ? OFW'((1 << rsp.siz) - 1 - i) : OFW'(i);
        r_lane   = (rsp.off + r_idx) & OFM;
        rdt_b[i] = rdt_lane[r_lane];
      end
    end
  end

  assign sub_rdt = rdt_b;
  assign sub_err = man_err | rsp.mal;

endmodule

// File: tb/tb_tcb_phy_converter.sv
// Directed bench: little- and big-endian converters, each backed by a small byte memory.
module tb_tcb_phy_converter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sub_vld = 1'b0;
  logic        sub_wen = 1'b0;
  logic [31:0] sub_adr = '0;
  logic [1:0]  sub_siz = '0;
  logic [31:0] sub_wdt = '0;
  logic        man_rdy = 1'b1;
  logic        man_err = 1'b0;

  logic        u0_sub_rdy, u0_sub_err, u0_man_vld, u0_man_wen, u0_mal;
  logic [31:0] u0_sub_rdt, u0_man_adr, u0_man_wdt;
  logic [3:0]  u0_man_ben;
  logic [31:0] u0_man_rdt = 32'hA5A5A5C3;
  logic        u1_sub_rdy, u1_sub_err, u1_man_vld, u1_man_wen, u1_mal;
  logic [31:0] u1_sub_rdt, u1_man_adr, u1_man_wdt;
  logic [3:0]  u1_man_ben;
  logic [31:0] u1_man_rdt = 32'hA5A5A5C3;

  logic [31:0] mem0 [64];
  logic [31:0] mem1 [64];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tcb_phy_converter #(.DLY(1), .ADR(32), .DAT(32), .ORD(0)) u0 (
    .clk(clk), .rst(rst),
    .sub_vld(sub_vld), .sub_rdy(u0_sub_rdy), .sub_wen(sub_wen), .sub_adr(sub_adr),
    .sub_siz(sub_siz), .sub_wdt(sub_wdt), .sub_rdt(u0_sub_rdt), .sub_err(u0_sub_err),
    .man_vld(u0_man_vld), .man_rdy(man_rdy), .man_wen(u0_man_wen), .man_adr(u0_man_adr),
    .man_ben(u0_man_ben), .man_wdt(u0_man_wdt), .man_rdt(u0_man_rdt), .man_err(man_err),
    .mal(u0_mal)
  );

  tcb_phy_converter #(.DLY(1), .ADR(32), .DAT(32), .ORD(1)) u1 (
    .clk(clk), .rst(rst),
    .sub_vld(sub_vld), .sub_rdy(u1_sub_rdy), .sub_wen(sub_wen), .sub_adr(sub_adr),
    .sub_siz(sub_siz), .sub_wdt(sub_wdt), .sub_rdt(u1_sub_rdt), .sub_err(u1_sub_err),
    .man_vld(u1_man_vld), .man_rdy(man_rdy), .man_wen(u1_man_wen), .man_adr(u1_man_adr),
    .man_ben(u1_man_ben), .man_wdt(u1_man_wdt), .man_rdt(u1_man_rdt), .man_err(man_err),
    .mal(u1_mal)
  );

  // Memory-style subordinates with one cycle of read latency, not affected by rst.
  always @(posedge clk) begin
    if (u0_man_vld && man_rdy) begin
      if (u0_man_wen) begin
        for (int b = 0; b < 4; b++)
          if (u0_man_ben[b]) mem0[u0_man_adr[7:2]][b*8 +: 8] <= u0_man_wdt[b*8 +: 8];
      end else begin
        u0_man_rdt <= mem0[u0_man_adr[7:2]];
      end
    end
    if (u1_man_vld && man_rdy) begin
      if (u1_man_wen) begin
        for (int b = 0; b < 4; b++)
          if (u1_man_ben[b]) mem1[u1_man_adr[7:2]][b*8 +: 8] <= u1_man_wdt[b*8 +: 8];
      end else begin
        u1_man_rdt <= mem1[u1_man_adr[7:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic w, input logic [31:0] a, input logic [1:0] s,
                     input logic [31:0] d);
    @(negedge clk);
    sub_vld = 1'b1;
    sub_wen = w;
    sub_adr = a;
    sub_siz = s;
    sub_wdt = d;
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    sub_vld = 1'b0;
    sub_wen = 1'b0;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end

    // Reset: cleared pipeline gives byte 0 of man_rdt and a bare man_err.
    #12;
    chk("rst_rdt", u0_sub_rdt, 32'h000000C3);
    chk("rst_rdt_be", u1_sub_rdt, 32'h000000C3);
    chk("rst_err0", {31'd0, u0_sub_err}, 32'd0);
    man_err = 1'b1;
    #1;
    chk("rst_err1", {31'd0, u0_sub_err}, 32'd1);
    man_err = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    req(1'b1, 32'h11, 2'd0, 32'h32);
    chk("w8_ben", {28'd0, u0_man_ben}, 32'h2);
    chk("w8_wdt", u0_man_wdt, 32'h00003200);
    chk("w8_mal", {31'd0, u0_mal}, 32'd0);
    chk("w8_vld", {31'd0, u0_man_vld}, 32'd1);
    chk("w8_adr", u0_man_adr, 32'h11);
    req(1'b1, 32'h10, 2'd0, 32'h10);
    req(1'b1, 32'h12, 2'd0, 32'h54);
    req(1'b1, 32'h13, 2'd0, 32'h76);
    req(1'b1, 32'h22, 2'd1, 32'h7654);
    chk("w16_ben", {28'd0, u0_man_ben}, 32'hC);
    chk("w16_wdt", u0_man_wdt, 32'h76540000);
    req(1'b1, 32'h30, 2'd2, 32'h76543210);
    chk("w32_ben", {28'd0, u0_man_ben}, 32'hF);
    chk("w32_wdt", u0_man_wdt, 32'h76543210);

    req(1'b0, 32'h13, 2'd0, 32'h0);
    idle();
    chk("r8_rdt", u0_sub_rdt, 32'h00000076);
    chk("r8_err", {31'd0, u0_sub_err}, 32'd0);
    req(1'b0, 32'h10, 2'd2, 32'h0);
    idle();
    chk("r32_rdt", u0_sub_rdt, 32'h76543210);
    req(1'b0, 32'h22, 2'd1, 32'h0);
    idle();
    chk("r16_rdt", u0_sub_rdt, 32'h00007654);

    // Size above the bus width is clamped to a full word.
    req(1'b0, 32'h10, 2'd3, 32'h0);
    chk("r64_mal", {31'd0, u0_mal}, 32'd0);
    chk("r64_ben", {28'd0, u0_man_ben}, 32'hF);
    idle();
    chk("r64_rdt", u0_sub_rdt, 32'h76543210);

    // Back-to-back reads each realign with their own metadata.
    req(1'b0, 32'h10, 2'd0, 32'h0);
    req(1'b0, 32'h12, 2'd1, 32'h0);
    chk("b2b_rdt0", u0_sub_rdt, 32'h00000010);
    idle();
    chk("b2b_rdt1", u0_sub_rdt, 32'h00007654);

    // Misaligned halfword: forwarded, flagged, and reported as an error.
    req(1'b1, 32'h21, 2'd1, 32'hBEEF);
    chk("mis_mal", {31'd0, u0_mal}, 32'd1);
    chk("mis_ben", {28'd0, u0_man_ben}, 32'h6);
    chk("mis_wdt", u0_man_wdt, 32'h00BEEF00);
    idle();
    chk("mis_err", {31'd0, u0_sub_err}, 32'd1);
    req(1'b0, 32'h30, 2'd2, 32'h0);
    idle();
    chk("aln_err", {31'd0, u0_sub_err}, 32'd0);
    chk("aln_rdt", u0_sub_rdt, 32'h76543210);

    // Idle request on an odd address never flags.
    @(negedge clk);
    sub_adr = 32'h23;
    sub_siz = 2'd2;
    #1;
    chk("idle_mal", {31'd0, u0_mal}, 32'd0);

    // Downstream error passes through on an aligned response.
    req(1'b0, 32'h10, 2'd2, 32'h0);
    idle();
    man_err = 1'b1;
    #1;
    chk("man_err", {31'd0, u0_sub_err}, 32'd1);
    man_err = 1'b0;

    // Big endian lane placement and readback.
    req(1'b1, 32'h20, 2'd1, 32'h3210);
    chk("be_wdt", u1_man_wdt, 32'h00001032);
    chk("be_ben", {28'd0, u1_man_ben}, 32'h3);
    req(1'b0, 32'h20, 2'd1, 32'h0);
    idle();
    chk("be_r16", u1_sub_rdt, 32'h00003210);
    req(1'b0, 32'h21, 2'd0, 32'h0);
    idle();
    chk("be_r8", u1_sub_rdt, 32'h00000010);

    // Reset while a word read is outstanding drops its metadata.
    req(1'b0, 32'h10, 2'd2, 32'h0);
    @(posedge clk);
    #2;
    sub_vld = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_rdt", u0_sub_rdt, 32'h00000010);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    req(1'b0, 32'h12, 2'd1, 32'h0);
    idle();
    chk("post_rst_rdt", u0_sub_rdt, 32'h00007654);
    chk("post_rst_err", {31'd0, u0_sub_err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
